// File: rtl/fetch_queue.sv
// Decoupling queue between IF and ID: buffers {pc, instr, pred_taken, pred_trgt}
// with valid/ready on both sides, first-word-fall-through read and synchronous flush.
package global_params;
    parameter int DATA_WIDTH  = 32;
    parameter int INSTR_WIDTH = 32;
endpackage

module fetch_queue #(
    parameter int                     DATA_WIDTH  = global_params::DATA_WIDTH,
    parameter int                     INSTR_WIDTH = global_params::INSTR_WIDTH,
    parameter int                     DEPTH       = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [DATA_WIDTH-1:0]    enq_pc,
    input  logic [INSTR_WIDTH-1:0]   enq_instr,
    input  logic                     enq_pred_taken,
    input  logic [DATA_WIDTH-1:0]    enq_pred_trgt,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [DATA_WIDTH-1:0]    deq_pc,
    output logic [INSTR_WIDTH-1:0]   deq_instr,
    output logic                     deq_pred_taken,
    output logic [DATA_WIDTH-1:0]    deq_pred_trgt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and >= 2");
    end

    logic [DATA_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic                   taken_mem [DEPTH];
    logic [DATA_WIDTH-1:0]  trgt_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             enq_fire;
    logic             deq_fire;

    assign enq_ready = (count != FULL);
    assign deq_valid = (count != '0);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    // Empty queue presents a NOP bubble rather than stale storage.
    always_comb begin
        deq_pc         = '0;
        deq_instr      = NOP_INSTR;
        deq_pred_taken = 1'b0;
        deq_pred_trgt  = '0;
        if (deq_valid) begin
            deq_pc         = pc_mem[rd_ptr];
            deq_instr      = instr_mem[rd_ptr];
            deq_pred_taken = taken_mem[rd_ptr];
            deq_pred_trgt  = trgt_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            pc_mem[wr_ptr]    <= enq_pc;
            instr_mem[wr_ptr] <= enq_instr;
            taken_mem[wr_ptr] <= enq_pred_taken;
            trgt_mem[wr_ptr]  <= enq_pred_trgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_pc = '0;
    logic [31:0] enq_instr = '0;
    logic        enq_pred_taken = 1'b0;
    logic [31:0] enq_pred_trgt = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_pred_taken;
    logic [31:0] deq_pred_trgt;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
        .enq_instr(enq_instr), .enq_pred_taken(enq_pred_taken),
        .enq_pred_trgt(enq_pred_trgt),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
        .deq_instr(deq_instr), .deq_pred_taken(deq_pred_taken),
        .deq_pred_trgt(deq_pred_trgt), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".deq_valid"}, deq_valid, 0);
        check({tag, ".count"}, count, 0);
        check({tag, ".enq_ready"}, enq_ready, 1);
        check({tag, ".deq_pc"}, deq_pc, 0);
        check({tag, ".deq_instr"}, deq_instr, 32'h00000013);
        check({tag, ".deq_taken"}, deq_pred_taken, 0);
        check({tag, ".deq_trgt"}, deq_pred_trgt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 check_empty("reset");
        #9 rst_n = 1'b1;

        // Fill to full with ID stalled
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'(4 * i);
            enq_instr = 32'hA0 + 32'(i);
            step();
            check("fill.count", count, 64'(i + 1));
            check("fill.head", deq_pc, 0);
        end
        check("full.enq_ready", enq_ready, 0);
        check("full.deq_instr", deq_instr, 32'hA0);
        enq_pc = 32'h10;
        step();
        check("fifth.count", count, 4);
        check("fifth.head", deq_pc, 0);

        // Drain in order
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain.pc", deq_pc, 64'(4 * i));
            check("drain.instr", deq_instr, 64'(32'hA0 + i));
            step();
        end
        deq_ready = 1'b0;
        check_empty("drained");

        // Streaming with one entry resident, pointers wrap
        enq_valid = 1'b1;
        enq_pc    = 32'h100;
        enq_instr = 32'h1;
        step();
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_pc = 32'h104 + 32'(4 * i);
            check("stream.pc", deq_pc, 64'(32'h100 + 4 * i));
            check("stream.count", count, 1);
            step();
        end
        check("stream.end_pc", deq_pc, 32'h128);
        enq_valid = 1'b0;
        step();
        deq_ready = 1'b0;
        check("stream.drained", count, 0);

        // Flush with simultaneous enq and deq
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_pc = 32'h180 + 32'(4 * i);
            step();
        end
        check("preflush.count", count, 3);
        flush     = 1'b1;
        enq_pc    = 32'h200;
        deq_ready = 1'b1;
        step();
        flush     = 1'b0;
        deq_ready = 1'b0;
        check("flush.count", count, 0);
        check("flush.deq_valid", deq_valid, 0);
        check("flush.deq_pc", deq_pc, 0);
        enq_pc = 32'h300;
        step();
        enq_valid = 1'b0;
        check("postflush.valid", deq_valid, 1);
        check("postflush.pc", deq_pc, 32'h300);
        check("postflush.count", count, 1);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("postflush.drained", count, 0);

        // Prediction fields carried through
        enq_valid      = 1'b1;
        enq_pc         = 32'h40;
        enq_instr      = 32'h55;
        enq_pred_taken = 1'b1;
        enq_pred_trgt  = 32'h80;
        step();
        enq_valid      = 1'b0;
        enq_pred_taken = 1'b0;
        enq_pred_trgt  = '0;
        check("pred.pc", deq_pc, 32'h40);
        check("pred.instr", deq_instr, 32'h55);
        check("pred.taken", deq_pred_taken, 1);
        check("pred.trgt", deq_pred_trgt, 32'h80);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check_empty("pred.drained");

        // Asynchronous reset mid-cycle with entries resident
        enq_valid = 1'b1;
        enq_pc    = 32'h500;
        step();
        enq_pc = 32'h504;
        step();
        enq_valid = 1'b0;
        check("prereset.count", count, 2);
        #2 rst_n = 1'b0;
        #1 check_empty("async_reset");
        step();
        rst_n = 1'b1;
        step();
        check_empty("after_reset");
        enq_valid = 1'b1;
        enq_pc    = 32'h600;
        step();
        enq_valid = 1'b0;
        check("after_reset.head", deq_pc, 32'h600);
        check("after_reset.count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction queue between the IF stage and the ID stage.
- Buffers fetched {pc, instr, predicted-taken, predicted-target} tuples with valid/ready handshakes on both sides.
- Absorbs ID stalls without freezing the PC register.
- A synchronous flush from branch resolution discards every wrong-path entry.

Parameters:
- DATA_WIDTH, global_params::DATA_WIDTH (32): width of PC and predicted target.
- INSTR_WIDTH, global_params::INSTR_WIDTH (32): instruction width.
- DEPTH, 4: entry count; power of two, >= 2.
- NOP_INSTR, 32'h00000013: encoding driven on deq_instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  discard all entries, including any same-cycle enqueue.
- enq_valid  input  1  IF presents a fetched instruction.
- enq_ready  output  1  queue can accept an entry this cycle.
- enq_pc  input  DATA_WIDTH  PC of the fetched instruction.
- enq_instr  input  INSTR_WIDTH  fetched instruction.
- enq_pred_taken  input  1  BTB hit / predicted taken.
- enq_pred_trgt  input  DATA_WIDTH  predicted target.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  ID consumes the head this cycle.
- deq_pc  output  DATA_WIDTH  head PC.
- deq_instr  output  INSTR_WIDTH  head instruction.
- deq_pred_taken  output  1  head prediction.
- deq_pred_trgt  output  DATA_WIDTH  head predicted target.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is asynchronous, active-low, and clears wr_ptr, rd_ptr and count to 0 immediately. Storage contents are not reset.
- Reset output values: deq_valid=0, enq_ready=1, count=0, deq_pc=0, deq_instr=NOP_INSTR, deq_pred_taken=0, deq_pred_trgt=0.
- Handshake: enqueue fires when enq_valid && enq_ready; dequeue fires when deq_valid && deq_ready. Fire events take effect at the next rising edge.
- enq_ready = (count != DEPTH). It is not combinationally dependent on deq_ready, so there is no enqueue into a full queue even when a dequeue fires in the same cycle.
- deq_valid = (count != 0).
- First-word-fall-through: deq_* are read combinationally from storage[rd_ptr]. An entry enqueued at edge N is visible on deq_* in the cycle after edge N (latency 1). There is no same-cycle bypass.
- Empty queue: deq_pc=0, deq_instr=NOP_INSTR, deq_pred_taken=0, deq_pred_trgt=0, so ID sees a bubble.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- count update: +1 on enqueue only; -1 on dequeue only; unchanged when both fire.
- Simultaneous events:
  - Full queue, deq fire: count-1; enq_ready is 1 the next cycle.
  - Empty queue, enq fire: count=1 next cycle (deq cannot fire).
  - Partial queue, enq and deq both fire: count unchanged, both pointers advance.
- Flush: highest priority. At the next edge, wr_ptr=rd_ptr=0 and count=0; any same-cycle enqueue and dequeue are ignored. deq_valid is 0 the cycle after flush. enq_valid may be accepted again the cycle after flush.
- Reset mid-operation: outputs return to reset values asynchronously. Entries are lost and must not reappear after deassertion.
- DEPTH not a power of two, or < 2: elaboration $error.
- Throughput: one enqueue and one dequeue per cycle sustained when partially full.

Test Plan:
- Reset, then enqueue pc=0x00,0x04,0x08,0x0C with instr 0xA0..0xA3 while deq_ready=0 -> count=4, enq_ready=0, deq_pc=0x00, deq_instr=0xA0. A fifth enq_valid is not accepted.
- Full queue, then deq_ready=1 for 4 cycles with enq_valid=0 -> deq_pc sequence 0x00,0x04,0x08,0x0C. Then count=0, deq_valid=0, deq_instr=0x00000013.
- DEPTH=4, continuous enq and deq for 10 cycles starting with 1 entry (pc=0x100..) -> count stays 1, pointers wrap, and output PCs are strictly in order 0x100,0x104,... with no loss or duplication.
- 3 entries queued, assert flush with enq_valid=1 (pc=0x200) and deq_ready=1 -> next cycle count=0, deq_valid=0, pc 0x200 absent. Following enqueue of pc=0x300 appears as head one cycle later.
- Enqueue pc=0x40, pred_taken=1, pred_trgt=0x80 -> dequeued tuple matches exactly: pred_taken=1, pred_trgt=0x80.
- 2 entries queued, drop rst_n asynchronously mid-cycle -> deq_valid=0, count=0 before the next edge. After release, the queue is empty and the old entries never appear.
